// File: rtl/pe_start_srl_fifo_ctrl_if.sv
// Handshake and storage-side bundle of the SRL start-token FIFO controller.
// The slave modport is the controller's view; master is its environment's.
interface pe_start_srl_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
);
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic                  srl_we;
  logic [ADDR_WIDTH-1:0] srl_addr;
  logic [DATA_WIDTH-1:0] srl_din;
  logic [DATA_WIDTH-1:0] srl_dout;
  logic [ADDR_WIDTH:0]   usedw;
  logic                  overflow_err;
  logic                  underflow_err;

  modport slave (
    input  if_write_ce,
    input  if_write,
    input  if_din,
    output if_full_n,
    input  if_read_ce,
    input  if_read,
    output if_dout,
    output if_empty_n,
    output srl_we,
    output srl_addr,
    output srl_din,
    input  srl_dout,
    output usedw,
    output overflow_err,
    output underflow_err
  );

  modport master (
    output if_write_ce,
    output if_write,
    output if_din,
    input  if_full_n,
    output if_read_ce,
    output if_read,
    input  if_dout,
    input  if_empty_n,
    input  srl_we,
    input  srl_addr,
    input  srl_din,
    output srl_dout,
    input  usedw,
    input  overflow_err,
    input  underflow_err
  );
endinterface

// File: rtl/pe_start_srl_fifo_ctrl.sv
// Occupancy, flags and read addressing for an SRL-based start-token FIFO.
// Storage shifts on every push; the oldest entry always sits at cnt-1.
module pe_start_srl_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input logic clk,
  input logic reset,
  pe_start_srl_fifo_ctrl_if.slave bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [CW-1:0]   cnt_m1;
  logic            empty_n;
  logic            full_n;
  logic [CW-1:0]   used;
  logic            ovf;
  logic            unf;
  logic            push;
  logic            pop;
  logic            wr_req;
  logic            rd_req;
  logic [DATA_WIDTH-1:0] din;

  assign wr_req = bus.if_write & bus.if_write_ce;
  assign rd_req = bus.if_read & bus.if_read_ce;
  assign push   = wr_req & full_n & ~reset;
  assign pop    = rd_req & empty_n;

  assign din         = bus.if_din;
  assign bus.srl_din = din;
  assign bus.if_dout = bus.srl_dout;
  assign bus.srl_we  = push;

  // Address comes from the registered count, so a pop-only cycle
  // exposes the next oldest entry one cycle later.
  assign cnt_m1       = cnt - ONE;
  assign bus.srl_addr = (cnt == '0) ? '0 : cnt_m1[ADDR_WIDTH-1:0];

  assign bus.if_empty_n    = empty_n;
  assign bus.if_full_n     = full_n;
  assign bus.usedw         = used;
  assign bus.overflow_err  = ovf;
  assign bus.underflow_err = unf;

  always_comb begin
    cnt_next   = cnt;
    state_next = state;
    unique case (1'b1)
      push & ~pop: cnt_next = cnt + ONE;
      ~push & pop: cnt_next = cnt - ONE;
      default:     cnt_next = cnt;
    endcase
    case (state)
      S_EMPTY: begin
        if (push) state_next = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (push && !pop && cnt == FULL_CNT - ONE)
          state_next = S_FULL;
        else if (pop && !push && cnt == ONE)
          state_next = S_EMPTY;
      end
      S_FULL: begin
        if (pop) state_next = S_PARTIAL;
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_EMPTY;
      cnt     <= '0;
      empty_n <= 1'b0;
      full_n  <= 1'b1;
      used    <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      empty_n <= (cnt_next != '0);
      full_n  <= (cnt_next != FULL_CNT);
      used    <= cnt_next;
      if (wr_req && !full_n)  ovf <= 1'b1;
      if (rd_req && !empty_n) unf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pe_start_srl_fifo_ctrl.sv
// Directed bench: DEPTH=2 and DEPTH=4 controllers, each with a
// behavioural shift-register storage model.
module tb_pe_start_srl_fifo_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2;
  logic rst4;
  int   n_chk  = 0;
  int   n_pass = 0;

  pe_start_srl_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) b2 ();
  pe_start_srl_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) b4 ();

  pe_start_srl_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)
  ) dut2 (
    .clk(clk), .reset(rst2), .bus(b2.slave)
  );

  pe_start_srl_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)
  ) dut4 (
    .clk(clk), .reset(rst4), .bus(b4.slave)
  );

  logic [7:0] m2 [2];
  logic [7:0] m4 [4];

  always_ff @(posedge clk) begin
    if (b2.srl_we) begin
      m2[1] <= m2[0];
      m2[0] <= b2.srl_din;
    end
  end
  assign b2.srl_dout = m2[b2.srl_addr];

  always_ff @(posedge clk) begin
    if (b4.srl_we) begin
      for (int i = 1; i < 4; i++) m4[i] <= m4[i-1];
      m4[0] <= b4.srl_din;
    end
  end
  assign b4.srl_dout = m4[b4.srl_addr];

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv2(input logic w, input logic wce, input logic [7:0] d,
                      input logic r, input logic rce);
    b2.if_write    = w;
    b2.if_write_ce = wce;
    b2.if_din      = d;
    b2.if_read     = r;
    b2.if_read_ce  = rce;
    #1;
  endtask

  task automatic drv4(input logic w, input logic [7:0] d, input logic r);
    b4.if_write    = w;
    b4.if_write_ce = 1'b1;
    b4.if_din      = d;
    b4.if_read     = r;
    b4.if_read_ce  = 1'b1;
    #1;
  endtask

  initial begin
    rst2 = 1'b1;
    rst4 = 1'b1;
    drv2(0, 0, 8'h00, 0, 0);
    drv4(0, 8'h00, 0);
    tick();
    tick();
    rst2 = 1'b0;
    rst4 = 1'b0;
    tick();

    // reset then idle
    chk("rst_empty_n", 16'(b2.if_empty_n), 16'h0);
    chk("rst_full_n", 16'(b2.if_full_n), 16'h1);
    chk("rst_usedw", 16'(b2.usedw), 16'h0);
    chk("rst_srl_we", 16'(b2.srl_we), 16'h0);
    chk("rst_ovf", 16'(b2.overflow_err), 16'h0);
    chk("rst_unf", 16'(b2.underflow_err), 16'h0);

    // fill and drain
    drv2(1, 1, 8'hA1, 0, 0);
    chk("fill_we", 16'(b2.srl_we), 16'h1);
    tick();
    chk("fill1_empty_n", 16'(b2.if_empty_n), 16'h1);
    chk("fill1_usedw", 16'(b2.usedw), 16'h1);
    chk("fill1_dout", 16'(b2.if_dout), 16'h00A1);
    drv2(1, 1, 8'hB2, 0, 0);
    tick();
    chk("fill2_full_n", 16'(b2.if_full_n), 16'h0);
    chk("fill2_usedw", 16'(b2.usedw), 16'h2);
    chk("fill2_dout", 16'(b2.if_dout), 16'h00A1);
    drv2(0, 1, 8'h00, 1, 1);
    chk("drain1_dout", 16'(b2.if_dout), 16'h00A1);
    tick();
    chk("drain1_usedw", 16'(b2.usedw), 16'h1);
    chk("drain1_full_n", 16'(b2.if_full_n), 16'h1);
    chk("drain2_dout", 16'(b2.if_dout), 16'h00B2);
    tick();
    chk("drain2_empty_n", 16'(b2.if_empty_n), 16'h0);
    chk("drain2_usedw", 16'(b2.usedw), 16'h0);
    drv2(0, 0, 8'h00, 0, 0);

    // simultaneous push and pop at cnt=1
    drv2(1, 1, 8'h11, 0, 0);
    tick();
    drv2(1, 1, 8'h22, 1, 1);
    chk("sim_addr_pre", 16'(b2.srl_addr), 16'h0);
    chk("sim_dout_pre", 16'(b2.if_dout), 16'h0011);
    tick();
    drv2(0, 0, 8'h00, 0, 0);
    chk("sim_usedw", 16'(b2.usedw), 16'h1);
    chk("sim_dout", 16'(b2.if_dout), 16'h0022);
    chk("sim_addr", 16'(b2.srl_addr), 16'h0);
    drv2(0, 0, 8'h00, 1, 1);
    tick();
    drv2(0, 0, 8'h00, 0, 0);
    chk("sim_drain_usedw", 16'(b2.usedw), 16'h0);

    // overflow while full
    drv2(1, 1, 8'h33, 0, 0);
    tick();
    drv2(1, 1, 8'h44, 0, 0);
    tick();
    drv2(1, 1, 8'hFF, 0, 0);
    chk("ovf_srl_we", 16'(b2.srl_we), 16'h0);
    tick();
    chk("ovf_usedw", 16'(b2.usedw), 16'h2);
    chk("ovf_flag", 16'(b2.overflow_err), 16'h1);
    drv2(0, 0, 8'h00, 0, 0);
    tick();
    chk("ovf_sticky", 16'(b2.overflow_err), 16'h1);
    chk("ovf_dout1", 16'(b2.if_dout), 16'h0033);
    drv2(0, 0, 8'h00, 1, 1);
    tick();
    chk("ovf_dout2", 16'(b2.if_dout), 16'h0044);
    tick();
    drv2(0, 0, 8'h00, 0, 0);
    chk("ovf_drained", 16'(b2.usedw), 16'h0);
    chk("ovf_still_set", 16'(b2.overflow_err), 16'h1);

    // clock-enable masking then underflow
    drv2(0, 0, 8'h00, 1, 0);
    tick();
    chk("unf_masked", 16'(b2.underflow_err), 16'h0);
    drv2(0, 0, 8'h00, 1, 1);
    tick();
    drv2(0, 0, 8'h00, 0, 0);
    chk("unf_flag", 16'(b2.underflow_err), 16'h1);
    chk("unf_usedw", 16'(b2.usedw), 16'h0);
    chk("unf_empty_n", 16'(b2.if_empty_n), 16'h0);

    // reset clears sticky errors
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    chk("rst_clr_ovf", 16'(b2.overflow_err), 16'h0);
    chk("rst_clr_unf", 16'(b2.underflow_err), 16'h0);

    // DEPTH=4: reset mid-transfer
    drv4(1, 8'h01, 0);
    tick();
    drv4(1, 8'h02, 0);
    tick();
    drv4(1, 8'h03, 0);
    tick();
    chk("d4_usedw3", 16'(b4.usedw), 16'h3);
    chk("d4_addr", 16'(b4.srl_addr), 16'h2);
    chk("d4_dout", 16'(b4.if_dout), 16'h0001);
    rst4 = 1'b1;
    drv4(1, 8'h04, 1);
    chk("d4_rst_we", 16'(b4.srl_we), 16'h0);
    tick();
    rst4 = 1'b0;
    drv4(0, 8'h00, 0);
    chk("d4_rst_usedw", 16'(b4.usedw), 16'h0);
    chk("d4_rst_empty_n", 16'(b4.if_empty_n), 16'h0);
    chk("d4_rst_full_n", 16'(b4.if_full_n), 16'h1);
    chk("d4_no_shift", 16'(m4[0]), 16'h0003);

    // DEPTH=4 refill to full after reset
    for (int i = 0; i < 4; i++) begin
      drv4(1, 8'(8'hC0 + i), 0);
      tick();
    end
    drv4(0, 8'h00, 0);
    chk("d4_full_n", 16'(b4.if_full_n), 16'h0);
    chk("d4_full_usedw", 16'(b4.usedw), 16'h4);
    chk("d4_full_dout", 16'(b4.if_dout), 16'h00C0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pe_start_srl_fifo_ctrl.md
Name: pe_start_srl_fifo_ctrl

Overview:
Control block for an SRL-based start-token FIFO that sits between a producer and a PE_i4xi4 processing-element instance in the Linear_Layer_i4xi4_q dataflow region. It keeps the occupancy state and the registered full/empty handshake flags. It drives the write-enable and read-address of an external addressable shift-register storage instance. The storage shifts its contents on every accepted write, and this block points the read address at the oldest entry.

Parameters:
DATA_WIDTH, 1, width of one FIFO entry
ADDR_WIDTH, 1, width of the storage read address; must satisfy 2**ADDR_WIDTH >= DEPTH
DEPTH, 2, number of entries; minimum value is 2

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
if_write_ce  in  1  write-side clock enable
if_write  in  1  producer write request
if_din  in  DATA_WIDTH  producer data
if_full_n  out  1  registered; 1 means space is available
if_read_ce  in  1  read-side clock enable
if_read  in  1  consumer read request
if_dout  out  DATA_WIDTH  oldest entry; equals srl_dout
if_empty_n  out  1  registered; 1 means data is valid
srl_we  out  1  storage shift-in enable
srl_addr  out  ADDR_WIDTH  storage read address
srl_din  out  DATA_WIDTH  storage write data; equals if_din
srl_dout  in  DATA_WIDTH  storage read data; combinational from srl_addr
usedw  out  ADDR_WIDTH+1  registered occupancy, range 0..DEPTH
overflow_err  out  1  sticky error flag
underflow_err  out  1  sticky error flag

Behaviour:
- Accept conditions:
  - push = if_write & if_write_ce & if_full_n
  - pop = if_read & if_read_ce & if_empty_n
- srl_we = push, combinational.
- srl_din = if_din and if_dout = srl_dout; both are pure pass-through.
- Occupancy register cnt (ADDR_WIDTH+1 bits), updated per cycle:
  - push only: cnt+1
  - pop only: cnt-1
  - push and pop together, or neither: unchanged
- srl_addr = cnt-1 when cnt>0, else 0. It is driven combinationally from the registered cnt, so on pop-only cycles the new oldest entry is addressed on the next cycle.
- Simultaneous push and pop:
  - cnt and srl_addr stay the same.
  - The shift discards the popped entry from index cnt-1 and moves the next-oldest entry into index cnt-1.
  - This is legal at any cnt in 1..DEPTH. When full (if_full_n=0), push is blocked, so only the pop takes effect.
- State is encoded as EMPTY (cnt=0), PARTIAL (0<cnt<DEPTH) and FULL (cnt=DEPTH). Transitions:
  - EMPTY to PARTIAL on push.
  - PARTIAL to FULL on push-only when cnt=DEPTH-1.
  - PARTIAL to EMPTY on pop-only when cnt=1.
  - FULL to PARTIAL on pop.
  - Every other case holds state.
- Flags are registered from the next value of cnt:
  - if_empty_n <= (cnt_next != 0)
  - if_full_n <= (cnt_next != DEPTH)
  - usedw <= cnt_next
- Latency:
  - Write to visible: a write accepted in cycle t gives if_empty_n=1 and valid if_dout in cycle t+1.
  - A pop that frees a slot gives if_full_n=1 in the next cycle.
- Write while full: if_write & if_write_ce & ~if_full_n.
  - No shift and no state change.
  - overflow_err is set and stays set until reset.
- Read while empty: if_read & if_read_ce & ~if_empty_n.
  - No state change.
  - underflow_err is set and stays set until reset.
- A deasserted clock enable masks its side completely. The request is ignored and no error is flagged.
- Reset, at any time including mid-transfer:
  - cnt=0, if_empty_n=0, if_full_n=1, usedw=0, overflow_err=0, underflow_err=0.
  - srl_we is 0 during reset cycles; push is gated by ~reset.
  - Storage contents are not cleared. They are invalid until rewritten.
- if_dout is undefined whenever if_empty_n=0.

Test Plan:
- Reset then idle: assert reset for 2 cycles and release -> if_empty_n=0, if_full_n=1, usedw=0, srl_we=0, both error flags 0.
- Fill and drain with DEPTH=2, DATA_WIDTH=8: write 0xA1 then 0xB2 on consecutive cycles, then read twice -> if_full_n=0 after the second write, usedw=2, if_dout=0xA1 then 0xB2, if_empty_n=0 one cycle after the second read.
- Simultaneous push and pop at cnt=1 holding 0x11: write 0x22 and read in the same cycle -> usedw stays 1, next if_dout=0x22, srl_addr stays 0.
- Overflow: with DEPTH=2 full, assert if_write & if_write_ce with 0xFF -> srl_we=0, usedw=2, overflow_err=1 and it persists; subsequent reads return the original two entries.
- Clock-enable masking and underflow: when empty, assert if_read with if_read_ce=0 -> underflow_err=0; then assert if_read_ce=1 -> underflow_err=1, usedw=0.
- Reset mid-operation with DEPTH=4: write 3 entries, then assert reset in the same cycle as a write and a read -> next cycle usedw=0, if_empty_n=0, if_full_n=1, srl_we was 0 during the reset cycle.
